// File: rtl/led_matrix_driver.sv
// rtl/led_matrix_driver.sv - 8x8 LED matrix scanner with double-buffered frame store
module led_matrix_driver #(
    parameter int DWELL = 1000,
    parameter int BLANK = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [5:0] wr_addr,
    input  logic       wr_data,
    output logic       wr_ready,
    input  logic       clr,
    input  logic       swap_req,
    output logic       swap_done,
    output logic       frame_done,
    output logic [7:0] row_sel,
    output logic [7:0] col_data
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t        state, state_nx;
    logic [2:0]    row, row_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [63:0]   back, back_nx, front;
    logic          pending, pending_nx;
    logic          boundary, do_swap, wr_acc, clr_acc;

    always_comb begin
        state_nx = state;
        row_nx   = row;
        cnt_nx   = cnt + 1'b1;
        boundary = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == CW'(BLANK - 1)) begin
                    state_nx = ST_SHOW;
                    cnt_nx   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == CW'(DWELL - 1)) begin
                    state_nx = ST_BLANK;
                    cnt_nx   = '0;
                    row_nx   = row + 3'd1;
                    boundary = (row == 3'd7);
                end
            end
            default: begin
                state_nx = ST_BLANK;
                cnt_nx   = '0;
            end
        endcase
    end

    // A request arriving exactly on the boundary edge swaps immediately without ever pending.
    assign do_swap = boundary & (pending | swap_req);
    assign wr_acc  = wr_valid & wr_ready;
    assign clr_acc = clr & wr_ready;

    always_comb begin
        pending_nx = do_swap ? 1'b0 : (pending | swap_req);
        back_nx    = clr_acc ? 64'd0 : back;
        if (wr_acc) begin
            back_nx[wr_addr] = wr_data;
        end
    end

    // Outputs are registered from next-state so they line up with the scan state itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_BLANK;
            row        <= 3'd0;
            cnt        <= '0;
            back       <= 64'd0;
            front      <= 64'd0;
            pending    <= 1'b0;
            wr_ready   <= 1'b0;
            swap_done  <= 1'b0;
            frame_done <= 1'b0;
            row_sel    <= 8'd0;
            col_data   <= 8'd0;
        end else begin
            state      <= state_nx;
            row        <= row_nx;
            cnt        <= cnt_nx;
            back       <= back_nx;
            pending    <= pending_nx;
            wr_ready   <= ~pending_nx;
            swap_done  <= do_swap;
            frame_done <= boundary;
            if (do_swap) begin
                front <= back;
            end
            if (state_nx == ST_SHOW) begin
                row_sel  <= 8'd1 << row_nx;
                col_data <= front[{row_nx, 3'b000} +: 8];
            end else begin
                row_sel  <= 8'd0;
                col_data <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_led_matrix_driver.sv
// tb/tb_led_matrix_driver.sv - randomized self-checking bench for led_matrix_driver
module tb_led_matrix_driver;
    localparam int DW = 4;
    localparam int BL = 2;
    localparam int P  = DW + BL;
    localparam int F  = 8 * P;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic       wr_data;
    logic       wr_ready;
    logic       clr;
    logic       swap_req;
    logic       swap_done;
    logic       frame_done;
    logic [7:0] row_sel;
    logic [7:0] col_data;

    int checks   = 0;
    int failures = 0;

    // Reference model: scan position is derived from the edge count since reset.
    int t;
    bit m_front[64];
    bit m_back[64];
    bit m_pend;
    bit m_ready;
    bit m_swap;

    led_matrix_driver #(.DWELL(DW), .BLANK(BL)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .clr(clr), .swap_req(swap_req), .swap_done(swap_done), .frame_done(frame_done),
        .row_sel(row_sel), .col_data(col_data)
    );

    always #5 clock = ~clock;

    function automatic logic [18:0] exp_vec();
        int pos, r, w;
        logic [7:0] rs, cd;
        pos = t % F;
        r   = pos / P;
        w   = pos % P;
        rs  = 8'd0;
        cd  = 8'd0;
        if (w >= BL) begin
            rs = 8'(1 << r);
            for (int c = 0; c < 8; c++) cd[c] = m_front[r * 8 + c];
        end
        return {m_ready, m_swap, (t > 0 && pos == 0), rs, cd};
    endfunction

    task automatic model_reset();
        t = 0;
        m_pend = 0;
        m_ready = 0;
        m_swap = 0;
        for (int i = 0; i < 64; i++) begin
            m_front[i] = 0;
            m_back[i] = 0;
        end
    endtask

    task automatic tick();
        bit bnd, acc, clra;
        bnd  = ((t + 1) % F == 0);
        acc  = wr_valid && m_ready;
        clra = clr && m_ready;
        m_swap = 0;
        if (bnd && (m_pend || swap_req)) begin
            m_front = m_back;
            m_swap  = 1;
            m_pend  = 0;
        end else if (swap_req) begin
            m_pend = 1;
        end
        if (clra) for (int i = 0; i < 64; i++) m_back[i] = 0;
        if (acc) m_back[wr_addr] = wr_data;
        m_ready = !m_pend;
        @(posedge clock);
        #1;
        t++;
    endtask

    task automatic write_pixel(input logic [5:0] a, input logic d);
        bit ok;
        ok = 0;
        wr_valid = 1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < 4 * F && !ok; i++) begin
            ok = m_ready;
            tick();
        end
        wr_valid = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_timeout addr=%0h got=not_accepted exp=accepted", a);
        end
    endtask

    task automatic test_reset();
        wr_valid = 0; wr_addr = 0; wr_data = 0; clr = 0; swap_req = 0;
        reset = 0;
        model_reset();
        #22;
        checks++;
        if ({wr_ready, swap_done, frame_done, row_sel, col_data} !== 19'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {wr_ready, swap_done, frame_done, row_sel, col_data});
        end
        reset = 1;
        tick();
        checks++;
        if (wr_ready !== 1'b1 || {wr_ready, swap_done, frame_done, row_sel, col_data} !== exp_vec()) begin
            failures++;
            $display("FAIL reset_first_edge got=%h exp=%h", {wr_ready, swap_done, frame_done, row_sel, col_data}, exp_vec());
        end
    endtask

    task automatic test_scan();
        int lit_cycles, frames;
        lit_cycles = 0;
        frames = 0;
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            checks++;
            if ({wr_ready, swap_done, frame_done, row_sel, col_data} !== exp_vec() || $countones(row_sel) > 1) begin
                failures++;
                $display("FAIL scan_cadence t=%0d got=%h exp=%h", t, {wr_ready, swap_done, frame_done, row_sel, col_data}, exp_vec());
            end
            if (row_sel == 8'h01) lit_cycles++;
            if (frame_done) frames++;
        end
        checks++;
        if (lit_cycles != 2 * DW || frames != 2) begin
            failures++;
            $display("FAIL scan_counts got=row0:%0d frames:%0d exp=row0:%0d frames:2", lit_cycles, frames, 2 * DW);
        end
    endtask

    task automatic test_write_swap();
        bit seen;
        seen = 0;
        write_pixel(6'h09, 1'b1);
        swap_req = 1;
        tick();
        swap_req = 0;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL swap_blocks_ready got=%b exp=0", wr_ready);
        end
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            checks++;
            if ({wr_ready, swap_done, frame_done, row_sel, col_data} !== exp_vec()) begin
                failures++;
                $display("FAIL write_swap t=%0d got=%h exp=%h", t, {wr_ready, swap_done, frame_done, row_sel, col_data}, exp_vec());
            end
            if (swap_done && frame_done) seen = 1;
            if (row_sel == 8'h02 && seen) begin
                checks++;
                if (col_data !== 8'h02) begin
                    failures++;
                    $display("FAIL row1_pixel got=%h exp=02", col_data);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL swap_with_frame got=no_swap_done exp=swap_done");
        end
    endtask

    task automatic test_blocked();
        swap_req = 1;
        tick();
        swap_req = 0;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL blocked_ready got=%b exp=0", wr_ready);
        end
        write_pixel(6'($urandom_range(16, 63)), 1'b1);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < F + 2; i++) begin
                tick();
                checks++;
                if ({wr_ready, swap_done, frame_done, row_sel, col_data} !== exp_vec()) begin
                    failures++;
                    $display("FAIL blocked_write t=%0d got=%h exp=%h", t, {wr_ready, swap_done, frame_done, row_sel, col_data}, exp_vec());
                end
            end
            swap_req = (k == 0);
        end
        swap_req = 0;
    endtask

    task automatic test_clear();
        for (int a = 0; a < 64; a++) write_pixel(6'(a), 1'b1);
        clr = 1;
        write_pixel(6'h3F, 1'b1);
        clr = 0;
        swap_req = 1;
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            swap_req = 0;
            checks++;
            if ({wr_ready, swap_done, frame_done, row_sel, col_data} !== exp_vec()) begin
                failures++;
                $display("FAIL clear_write t=%0d got=%h exp=%h", t, {wr_ready, swap_done, frame_done, row_sel, col_data}, exp_vec());
            end
        end
    endtask

    task automatic test_boundary();
        int n;
        n = 0;
        write_pixel(6'($urandom), 1'b1);
        for (int i = 0; i < F && (t + 1) % F != 0; i++) tick();
        swap_req = 1;
        tick();
        swap_req = 0;
        checks++;
        if (swap_done !== 1'b1 || {wr_ready, swap_done, frame_done, row_sel, col_data} !== exp_vec()) begin
            failures++;
            $display("FAIL boundary_req got=%h exp=%h", {wr_ready, swap_done, frame_done, row_sel, col_data}, exp_vec());
        end
        for (int i = 0; i < F + 2; i++) begin
            swap_req = (i == 3 || i == 10 || i == 20);
            tick();
            checks++;
            if ({wr_ready, swap_done, frame_done, row_sel, col_data} !== exp_vec()) begin
                failures++;
                $display("FAIL repeat_req t=%0d got=%h exp=%h", t, {wr_ready, swap_done, frame_done, row_sel, col_data}, exp_vec());
            end
            if (swap_done) n++;
        end
        swap_req = 0;
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL repeat_swap_count got=%0d exp=1", n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * F; i++) begin
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_addr  = 6'($urandom);
            wr_data  = 1'($urandom);
            clr      = ($urandom_range(0, 60) == 0);
            swap_req = ($urandom_range(0, 30) == 0);
            tick();
            checks++;
            if ({wr_ready, swap_done, frame_done, row_sel, col_data} !== exp_vec()) begin
                failures++;
                $display("FAIL random_traffic t=%0d got=%h exp=%h", t, {wr_ready, swap_done, frame_done, row_sel, col_data}, exp_vec());
            end
        end
        wr_valid = 0; clr = 0; swap_req = 0;
    endtask

    task automatic test_midreset();
        for (int i = 0; i < F && (t % F) != 4 * P + BL + 1; i++) tick();
        checks++;
        if (row_sel !== 8'h10) begin
            failures++;
            $display("FAIL midreset_row4 got=%h exp=10", row_sel);
        end
        #2 reset = 0;
        #1;
        checks++;
        if ({wr_ready, row_sel, col_data} !== 17'd0) begin
            failures++;
            $display("FAIL midreset_async got=%h exp=0", {wr_ready, row_sel, col_data});
        end
        model_reset();
        #10 reset = 1;
        for (int i = 0; i < F + 4; i++) begin
            tick();
            checks++;
            if ({wr_ready, swap_done, frame_done, row_sel, col_data} !== exp_vec()) begin
                failures++;
                $display("FAIL midreset_restart t=%0d got=%h exp=%h", t, {wr_ready, swap_done, frame_done, row_sel, col_data}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write_swap();
        test_blocked();
        test_clear();
        test_boundary();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
